// File: rtl/gpio_uart_pkg.sv
// Shared types and constants for the GPIO-to-UART transmit bridge.
// Optional feature macro: GPIO_UART_PARITY_EN (adds an even-parity bit per frame).
package gpio_uart_pkg;

    localparam int unsigned GPIO_DATA_WIDTH = 8;
    localparam int unsigned BIT_IDX_W       = $clog2(GPIO_DATA_WIDTH);

    localparam logic TX_IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL   = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/gpio_uart_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is still accepted when a pop
// happens in the same cycle. Flags and count are registered.
module gpio_uart_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned AW         = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] head_c_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [AW:0]           count_o
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW:0]           count_q;
    logic [AW:0]           count_d;
    logic                  empty_q;
    logic                  full_q;
    logic                  do_push_c;
    logic                  do_pop_c;

    assign head_c_o = mem_q[rd_ptr_q];
    assign empty_o  = empty_q;
    assign full_o   = full_q;
    assign count_o  = count_q;

    // Accept/advance decisions and the resulting occupancy
    always_comb begin
        do_pop_c  = pop_i && !empty_q;
        do_push_c = push_i && (!full_q || do_pop_c);
        count_d   = count_q;
        if (do_push_c && !do_pop_c) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (do_pop_c && !do_push_c) begin
            count_d = count_q - (AW + 1)'(1);
        end
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers (wrap naturally at DEPTH) and registered flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            if (do_push_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == COUNT_FULL);
        end
    end

endmodule

// File: rtl/gpio_uart_tx_bridge.sv
// Queues bytes stored to the GPIO port and serialises them as UART frames
// (8N1, or 8E1 when GPIO_UART_PARITY_EN is defined). Never back-pressures the
// core; a byte that finds the queue full is dropped and flagged in overflow.
module gpio_uart_tx_bridge
    import gpio_uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = GPIO_DATA_WIDTH,
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned FIFO_AW    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  tx,
    output logic                  busy,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic [FIFO_AW:0]      fifo_count,
    output logic                  overflow
);

    localparam int unsigned BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    tx_state_t             state_q;
    logic [BAUD_W-1:0]     baud_q;
    logic [IDX_W-1:0]      bit_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  overflow_q;
    logic                  wr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
`ifdef GPIO_UART_PARITY_EN
    logic                  parity_q;
`endif

    logic                  baud_tick_c;
    logic                  pop_c;
    logic [DATA_WIDTH-1:0] fifo_head;

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign overflow = overflow_q;

    assign baud_tick_c = (baud_q == BAUD_LAST);
    assign pop_c = !fifo_empty &&
                   ((state_q == IDLE) || ((state_q == STOP) && baud_tick_c));

    gpio_uart_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_i   (wr_q),
        .pop_i    (pop_c),
        .wdata_i  (wdata_q),
        .head_c_o (fifo_head),
        .empty_o  (fifo_empty),
        .full_o   (fifo_full),
        .count_o  (fifo_count)
    );

    // Register the GPIO strobe; a dropped write latches the sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_q <= wr_en;
            if (wr_en) begin
                wdata_q <= wdata;
            end
            if (wr_q && fifo_full && !pop_c) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Frame sequencer: baud counter, bit index, shift register and registered tx
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= TX_IDLE_LEVEL;
            busy_q   <= 1'b0;
`ifdef GPIO_UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    if (pop_c) begin
                        shift_q  <= fifo_head;
`ifdef GPIO_UART_PARITY_EN
                        parity_q <= ^fifo_head;
`endif
                        state_q  <= START;
                        tx_q     <= START_LEVEL;
                        busy_q   <= 1'b1;
                    end
                end
                START: begin
                    if (baud_tick_c) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_tick_c) begin
                        baud_q  <= '0;
                        shift_q <= shift_q >> 1;
                        if (bit_q == IDX_LAST) begin
`ifdef GPIO_UART_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= STOP;
                            tx_q    <= TX_IDLE_LEVEL;
`endif
                        end else begin
                            bit_q <= bit_q + IDX_W'(1);
                            tx_q  <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
`ifdef GPIO_UART_PARITY_EN
                PARITY: begin
                    if (baud_tick_c) begin
                        baud_q  <= '0;
                        state_q <= STOP;
                        tx_q    <= TX_IDLE_LEVEL;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (baud_tick_c) begin
                        baud_q <= '0;
                        if (pop_c) begin
                            // Back-to-back frame: straight into the next start bit
                            shift_q  <= fifo_head;
`ifdef GPIO_UART_PARITY_EN
                            parity_q <= ^fifo_head;
`endif
                            state_q  <= START;
                            tx_q     <= START_LEVEL;
                        end else begin
                            state_q <= IDLE;
                            tx_q    <= TX_IDLE_LEVEL;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    baud_q  <= '0;
                    tx_q    <= TX_IDLE_LEVEL;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_uart_tx_bridge.sv
// Bench for gpio_uart_tx_bridge: a time-based reference model predicts queue
// occupancy, overflow and the tx waveform each cycle; a frame decoder on tx
// pops expected bytes from a scoreboard queue filled by the model.
module tb_gpio_uart_tx_bridge;

    localparam int unsigned DW    = 8;
    localparam int unsigned CD    = 4;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;
`ifdef GPIO_UART_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME = NBITS * CD;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          tx;
    logic          busy;
    logic          fifo_empty;
    logic          fifo_full;
    logic [AW:0]   fifo_count;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    gpio_uart_tx_bridge #(
        .DATA_WIDTH (DW),
        .CLK_DIV    (CD),
        .FIFO_AW    (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wdata      (wdata),
        .tx         (tx),
        .busy       (busy),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [DW-1:0] mq[$];       // bytes waiting in the queue
    logic [DW-1:0] exp_q[$];    // bytes expected on the line, in order
    int            cyc = 0;
    bit            in_frame = 1'b0;
    int            frame_start = 0;
    int            frame_end = 0;
    logic [DW-1:0] frame_byte = '0;
    bit            m_ovf = 1'b0;
    bit            pend_wr = 1'b0;
    logic [DW-1:0] pend_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic exp_tx();
        int idx;
        if (!in_frame) return 1'b1;
        idx = (cyc - frame_start) / CD;
        if (idx == 0) return 1'b0;
        if (idx <= DW) return frame_byte[idx-1];
`ifdef GPIO_UART_PARITY_EN
        if (idx == DW + 1) return ^frame_byte;
`endif
        return 1'b1;
    endfunction

    // A strobe seen at one edge reaches the queue at the next; the line takes a
    // new byte whenever it is free (idle, or at the end of a frame).
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            exp_q.delete();
            in_frame = 1'b0;
            m_ovf    = 1'b0;
            pend_wr  = 1'b0;
        end else begin
            int  sz;
            bit  pop;
            cyc++;
            sz  = mq.size();
            pop = (sz > 0) && (!in_frame || (cyc == frame_end));
            if (pop) begin
                frame_byte  = mq.pop_front();
                exp_q.push_back(frame_byte);
                frame_start = cyc;
                frame_end   = cyc + FRAME;
                in_frame    = 1'b1;
            end else if (in_frame && (cyc == frame_end)) begin
                in_frame = 1'b0;
            end
            if (pend_wr) begin
                if ((sz < DEPTH) || pop) mq.push_back(pend_data);
                else m_ovf = 1'b1;
            end
            pend_wr   = wr_en;
            pend_data = wdata;
        end
    end

    // ---------------- per-cycle compare and frame decoder ----------------
    bit               mon_act = 1'b0;
    int               mon_cnt = 0;
    logic [NBITS-1:0] mon_bits = '0;

    always @(negedge clk) begin
        if (reset) begin
            mon_act = 1'b0;
        end else begin
            check("tx_level", 32'(tx), 32'(exp_tx()));
            check("busy", 32'(busy), 32'(in_frame));
            check("fifo_count", 32'(fifo_count), 32'(mq.size()));
            check("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
            check("fifo_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
            check("overflow", 32'(overflow), 32'(m_ovf));

            if (!mon_act) begin
                if (tx === 1'b0) begin
                    mon_act  = 1'b1;
                    mon_cnt  = 0;
                    mon_bits = '0;
                end
            end else begin
                mon_cnt++;
            end
            if (mon_act && ((mon_cnt % CD) == CD / 2)) begin
                mon_bits[mon_cnt / CD] = tx;
                if ((mon_cnt / CD) == NBITS - 1) begin
                    logic [DW-1:0] got;
                    got = mon_bits[DW:1];
                    check("frame_start_bit", 32'(mon_bits[0]), 32'(0));
                    check("frame_stop_bit", 32'(mon_bits[NBITS-1]), 32'(1));
`ifdef GPIO_UART_PARITY_EN
                    check("frame_parity", 32'(mon_bits[DW+1]), 32'(^got));
`endif
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL frame_unexpected: got byte 0x%0h, expected no frame (cycle %0d)", got, cyc);
                    end else begin
                        check("frame_byte", 32'(got), 32'(exp_q.pop_front()));
                    end
                    mon_act = 1'b0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [DW-1:0] b);
        wr_en = 1'b1;
        wdata = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((busy !== 1'b0 || fifo_empty !== 1'b1 || in_frame || mq.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(t < 3000), 32'(1));
        repeat (3) @(negedge clk);
    endtask

    task automatic busy_len(input string name, input int exp_len);
        int t = 0;
        int n = 0;
        while (busy !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        while (busy === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n), 32'(exp_len));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'(1));
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_empty", 32'(fifo_empty), 32'(1));
        check("reset_full", 32'(fifo_full), 32'(0));
        check("reset_count", 32'(fifo_count), 32'(0));
        check("reset_overflow", 32'(overflow), 32'(0));
        #1 reset = 1'b0;
        @(negedge clk);

        // single byte from idle: start latency and frame length
        begin
            int lat = 0;
            send(8'hA5);
            while (busy !== 1'b1 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            check("start_latency", 32'(lat), 32'(2));
            begin
                int n = 0;
                while (busy === 1'b1 && n < 1000) begin
                    @(negedge clk);
                    n++;
                end
                check("busy_len_a5", 32'(n), 32'(FRAME));
            end
        end
        wait_idle("drain_a5");

        // back-to-back frames with no idle gap
        send(8'h00);
        send(8'hFF);
        busy_len("busy_len_00_ff", 2 * FRAME);
        wait_idle("drain_00_ff");
        check("empty_after_pair", 32'(fifo_empty), 32'(1));

        // parity example byte (frame length follows the build)
        send(8'h07);
        busy_len("busy_len_07", FRAME);
        wait_idle("drain_07");

        // six writes into a four-deep queue: the sixth is dropped
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55); send(8'h66);
        wait_idle("drain_burst6");
        check("overflow_sticky", 32'(overflow), 32'(1));

        // full queue, push coinciding with a pop at stop-bit expiry
        do_reset();
        send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4); send(8'hE5);
        repeat (FRAME - 4) @(negedge clk);
        send(8'h5A);
        check("full_before_swap", 32'(fifo_full), 32'(1));
        check("count_before_swap", 32'(fifo_count), 32'(4));
        @(negedge clk);
        check("count_after_swap", 32'(fifo_count), 32'(4));
        check("overflow_after_swap", 32'(overflow), 32'(0));
        wait_idle("drain_swap");

        // reset during data bit 3 with two bytes still queued
        send(8'h35); send(8'h9C); send(8'h42);
        repeat (17) @(negedge clk);
        check("tx_before_reset", 32'(tx), 32'(0));
        check("count_before_reset", 32'(fifo_count), 32'(2));
        #1 reset = 1'b1;
        #1;
        check("async_reset_tx", 32'(tx), 32'(1));
        check("async_reset_busy", 32'(busy), 32'(0));
        check("async_reset_count", 32'(fifo_count), 32'(0));
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        begin
            int lows = 0;
            repeat (100) begin
                @(negedge clk);
                if (tx !== 1'b1) lows++;
            end
            check("quiet_after_reset", 32'(lows), 32'(0));
        end

        // randomized bursts and gaps, occasional resets
        for (int r = 0; r < 30; r++) begin
            int len;
            if ($urandom_range(0, 4) == 0) do_reset();
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++) begin
                send(DW'($urandom));
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
            repeat ($urandom_range(0, 150)) @(negedge clk);
        end
        wait_idle("drain_random");
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        check("decoder_idle", 32'(mon_act), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
